led_sequencer: RTL

- Controller that sequences the four board LEDs through selectable patterns: chase up, chase down, ping-pong and blink-all.
- A programmable prescaler sets the step rate.
- Pattern changes arrive over a valid/ready handshake and are applied cleanly, with a blank gap between patterns.
- Sits between the board inputs (buttons/switch decoder) and the LED pins; it is the only driver of led_1..led_4.

---
 rtl/led_seq_pkg.sv | 60 ++++++
 rtl/led_sequencer_if.sv | 11 +
 rtl/led_sequencer_tick_gen.sv | 28 ++
 rtl/led_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and step helpers for the LED sequencer.
// Latency: combinational helpers only, no state.
// Backpressure: not applicable; holds mode codes, FSM encoding and step rules.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE_UP   = 2'd0,
        MODE_CHASE_DOWN = 2'd1,
        MODE_PING_PONG  = 2'd2,
        MODE_BLINK      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        SWITCH = 2'd3
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Position of the lit LED, ping-pong direction, blink phase (1 = on).
    typedef struct packed {
        logic [1:0] pos;
        logic       dir;
        logic       phase;
    } step_t;

    function automatic step_t start_step(input mode_e m);
        step_t s;
        s.pos   = (m == MODE_CHASE_DOWN) ? 2'd3 : 2'd0;
        s.dir   = DIR_UP;
        s.phase = 1'b1;
        return s;
    endfunction

    // Ping-pong flips direction on arrival at an end, so dir always names
    // the next move; the step after 1->0 is then exactly the start step.
    function automatic step_t next_step(input mode_e m, input step_t s);
        step_t n;
        n = s;
        case (m)
            MODE_CHASE_UP:   n.pos = s.pos + 2'd1;
            MODE_CHASE_DOWN: n.pos = s.pos - 2'd1;
            MODE_PING_PONG: begin
                if (s.dir == DIR_UP) begin
                    n.pos = s.pos + 2'd1;
                    if (n.pos == 2'd3) n.dir = DIR_DN;
                end else begin
                    n.pos = s.pos - 2'd1;
                    if (n.pos == 2'd0) n.dir = DIR_UP;
                end
            end
            default:         n.phase = ~s.phase;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Mode request channel: requester drives mode_sel/mode_valid, sequencer returns mode_ready.
// Latency: wires only.
// Backpressure: requester holds mode_valid and mode_sel stable until mode_ready is seen.
interface led_sequencer_if;
    logic [1:0] mode_sel;
    logic       mode_valid;
    logic       mode_ready;

    modport master (output mode_sel, output mode_valid, input mode_ready);
    modport slave  (input mode_sel, input mode_valid, output mode_ready);
endinterface

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler: pulses tick while enabled on the last of every TICK_DIV counted cycles.
// Latency: tick is combinational from the count register; count wraps to 0 on tick.
// Backpressure: en=0 freezes the count, clr forces it to 0 (clr wins over en).
// Ports: clk, rst (sync, active-high), en, clr, tick.
module led_sequencer_tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/led_sequencer.sv
// Sequences led_1..led_4 through chase-up/down, ping-pong and blink at a prescaled step rate.
// Latency: LEDs change 1 clk after the step register; cycle_done 1 clk after the wrapping tick.
// Backpressure: mode_ready only in IDLE/RUN; a different mode in RUN blanks LEDs for TICK_DIV clks.
// Ports: clk, rst (sync, active-high), en, pause, mode_if (slave: mode_sel/valid/ready),
//        cycle_done, led_1..led_4.
// Optional build macro LED_PWM_EN: gates lit LEDs with a 4-bit PWM at PWM_DUTY/16.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 2500000,
    parameter int PWM_DUTY = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pause,
    led_sequencer_if.slave  mode_if,
    output logic            cycle_done,
    output logic            led_1,
    output logic            led_2,
    output logic            led_3,
    output logic            led_4
);
    state_e     state, state_nx;
    mode_e      mode, mode_nx, pend, pend_nx, req_mode;
    step_t      step, step_nx;
    logic       done_nx;
    logic       cnt_en, cnt_clr, tick;
    logic       accept, sw_req;
    logic [3:0] led_dec, led_out, led_q;

    assign mode_if.mode_ready = !rst && (state == IDLE || state == RUN);
    assign accept   = mode_if.mode_valid && mode_if.mode_ready;
    assign req_mode = mode_e'(mode_if.mode_sel);
    assign sw_req   = accept && (state == RUN) && (req_mode != mode);

    // Same prescaler times both the step rate and the SWITCH blank gap.
    led_sequencer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        mode_nx  = mode;
        pend_nx  = pend;
        step_nx  = step;
        done_nx  = 1'b0;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr  = 1'b1;
                    mode_nx  = accept ? req_mode : mode;
                    step_nx  = start_step(mode_nx);
                    state_nx = RUN;
                end
                RUN: begin
                    // Switch beats both pause and a coincident tick.
                    if (sw_req) begin
                        pend_nx  = req_mode;
                        state_nx = SWITCH;
                        cnt_clr  = 1'b1;
                    end else if (pause) begin
                        state_nx = HOLD;
                    end else begin
                        cnt_en = 1'b1;
                        if (tick) begin
                            step_nx = next_step(mode, step);
                            done_nx = (step_nx == start_step(mode));
                        end
                    end
                end
                HOLD: begin
                    if (!pause) state_nx = RUN;
                end
                SWITCH: begin
                    cnt_en = 1'b1;
                    if (tick) begin
                        state_nx = RUN;
                        mode_nx  = pend;
                        step_nx  = start_step(pend);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        led_dec = 4'b0000;
        if (state == RUN || state == HOLD) begin
            if (mode == MODE_BLINK) led_dec = {4{step.phase}};
            else                    led_dec = 4'b0001 << step.pos;
        end
    end

`ifdef LED_PWM_EN
    localparam logic [4:0] DUTY = (PWM_DUTY >= 16) ? 5'd16 : 5'(PWM_DUTY);
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= 4'd0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign pwm_on  = ({1'b0, pwm_cnt} < DUTY);
    assign led_out = led_dec & {4{pwm_on}};
`else
    logic unused_pwm_duty;
    assign unused_pwm_duty = ^PWM_DUTY;
    assign led_out = led_dec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= MODE_CHASE_UP;
            pend       <= MODE_CHASE_UP;
            step       <= start_step(MODE_CHASE_UP);
            cycle_done <= 1'b0;
            led_q      <= 4'b0000;
        end else begin
            state      <= state_nx;
            mode       <= mode_nx;
            pend       <= pend_nx;
            step       <= step_nx;
            cycle_done <= done_nx;
            led_q      <= led_out;
        end
    end

    assign led_1 = led_q[0];
    assign led_2 = led_q[1];
    assign led_3 = led_q[2];
    assign led_4 = led_q[3];
endmodule
